// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit.
// Takes one instruction at a time over a valid/ready handshake and latches it
// in ir. It then steps through DECODE, EXEC, MEM and WB, and drives the datapath
// selects and the strobes. Every output depends on state and ir only. The one
// exception is pc_sel during a branch EXEC, which follows branch_taken.
module multicycle_controller #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter bit EN_UNSIGNED = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  output logic               instr_ready,
  input  logic               branch_taken,
  input  logic               mem_ack,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         alu_src,
  output logic [1:0]         pc_sel,
  output logic               pc_en,
  output logic [2:0]         wb_sel,
  output logic               reg_wr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               trap,
  output logic [1:0]         trap_cause
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [3:0] C_ALU   = 4'd0;
  localparam logic [3:0] C_LW    = 4'd1;
  localparam logic [3:0] C_SW    = 4'd2;
  localparam logic [3:0] C_BR    = 4'd3;
  localparam logic [3:0] C_JAL   = 4'd4;
  localparam logic [3:0] C_JALR  = 4'd5;
  localparam logic [3:0] C_LUI   = 4'd6;
  localparam logic [3:0] C_AUIPC = 4'd7;
  localparam logic [3:0] C_BAD   = 4'd8;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]  state, next_state;
  logic [31:0] ir;
  logic [7:0]  mem_cnt;
  logic        sw_done;
  logic [3:0]  cls;
  logic [3:0]  dec_op;
  logic [1:0]  dec_src;
  logic        legal;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  // The register operand fields belong to the datapath; this unit never reads them.
  logic unused_fields;
  assign unused_fields = ^ir[24:15];

  // Classify ir: instruction class, legality, ALU operation and operand source.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cls     = C_BAD;
    dec_op  = 4'd0;
    dec_src = 2'd0;
    legal   = 1'b0;
    case (opcode)
      7'b0110011: begin
        cls = C_ALU;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: begin legal = 1'b1; dec_op = 4'd0;  end
          {F7_ALT,  3'b000}: begin legal = 1'b1; dec_op = 4'd1;  end
          {F7_BASE, 3'b001}: begin legal = 1'b1; dec_op = 4'd2;  end
          {F7_BASE, 3'b010}: begin legal = 1'b1; dec_op = 4'd10; end
          {F7_BASE, 3'b011}: begin legal = EN_UNSIGNED; dec_op = 4'd12; end
          {F7_BASE, 3'b100}: begin legal = 1'b1; dec_op = 4'd7;  end
          {F7_BASE, 3'b101}: begin legal = 1'b1; dec_op = 4'd3;  end
          {F7_ALT,  3'b101}: begin legal = 1'b1; dec_op = 4'd4;  end
          {F7_BASE, 3'b110}: begin legal = 1'b1; dec_op = 4'd6;  end
          {F7_BASE, 3'b111}: begin legal = 1'b1; dec_op = 4'd5;  end
          default:           legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        cls     = C_ALU;
        dec_src = 2'd1;
        case (funct3)
          3'b000: begin legal = 1'b1; dec_op = 4'd0;  end
          3'b001: begin legal = (funct7 == F7_BASE); dec_op = 4'd2; end
          3'b010: begin legal = 1'b1; dec_op = 4'd10; end
          3'b011: begin legal = EN_UNSIGNED; dec_op = 4'd12; end
          3'b100: begin legal = 1'b1; dec_op = 4'd7;  end
          3'b101: begin
            legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            dec_op = (funct7 == F7_ALT) ? 4'd4 : 4'd3;
          end
          3'b110: begin legal = 1'b1; dec_op = 4'd6;  end
          default: begin legal = 1'b1; dec_op = 4'd5; end
        endcase
      end
      7'b0000011: begin cls = C_LW; dec_src = 2'd1; legal = (funct3 == 3'b010); end
      7'b0100011: begin cls = C_SW; dec_src = 2'd2; legal = (funct3 == 3'b010); end
      7'b1100011: begin
        cls = C_BR;
        case (funct3)
          3'b000:  begin legal = 1'b1; dec_op = 4'd8;  end
          3'b001:  begin legal = 1'b1; dec_op = 4'd11; end
          3'b100:  begin legal = 1'b1; dec_op = 4'd10; end
          3'b101:  begin legal = 1'b1; dec_op = 4'd9;  end
          3'b110:  begin legal = EN_UNSIGNED; dec_op = 4'd12; end
          3'b111:  begin legal = EN_UNSIGNED; dec_op = 4'd13; end
          default: legal = 1'b0;
        endcase
      end
      7'b1101111: begin cls = C_JAL; legal = 1'b1; end
      7'b1100111: begin cls = C_JALR; dec_src = 2'd1; legal = (funct3 == 3'b000); end
      7'b0110111: begin cls = C_LUI; legal = 1'b1; end
      7'b0010111: begin cls = C_AUIPC; legal = 1'b1; end
      default:    cls = C_BAD;
    endcase
  end

  // Next-state sequencing, including the memory-ack wait and its timeout.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (instr_valid) next_state = S_DECODE;
      S_DECODE: next_state = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (cls == C_LW || cls == C_SW) next_state = S_MEM;
        else if (cls == C_BR)           next_state = S_IDLE;
        else                            next_state = S_WB;
      end
      S_MEM: begin
        if (mem_ack)                      next_state = (cls == C_LW) ? S_WB : S_IDLE;
        else if (mem_cnt == TIMEOUT_LAST) next_state = S_TRAP;
      end
      default:  next_state = S_IDLE;
    endcase
  end

  // State, instruction register, MEM cycle counter and the store-completion strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ir      <= 32'd0;
      mem_cnt <= 8'd0;
      sw_done <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= next_state;
      if (state == S_IDLE && instr_valid) ir <= instr;
      mem_cnt <= (state == S_MEM && next_state == S_MEM) ? mem_cnt + 8'd1 : 8'd0;
      // The PC update for a completed store is registered. This keeps mem_ack off every output path.
      sw_done <= (state == S_MEM) && mem_ack && (cls == C_SW);
    end
  end

  // Output decode from state and ir. Anything not in use is driven 0.
  always_comb begin
    instr_ready = (state == S_IDLE);
    alu_op      = '0;
    alu_src     = 2'd0;
    pc_sel      = 2'd0;
    pc_en       = sw_done;
    wb_sel      = 3'd0;
    reg_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    trap        = 1'b0;
    trap_cause  = 2'd0;
    case (state)
      S_EXEC: begin
        alu_op  = ALUOP_W'(dec_op);
        alu_src = dec_src;
        if (cls == C_BR) begin
          pc_en  = 1'b1;
          pc_sel = branch_taken ? 2'd2 : 2'd0;
        end
      end
      S_MEM: begin
        alu_op  = ALUOP_W'(dec_op);
        alu_src = dec_src;
        mem_rd  = (cls == C_LW);
        mem_wr  = (cls == C_SW);
      end
      S_WB: begin
        alu_op  = ALUOP_W'(dec_op);
        alu_src = dec_src;
        reg_wr  = (ir[11:7] != 5'd0);
        pc_en   = 1'b1;
        case (cls)
          C_JAL:   pc_sel = 2'd1;
          C_JALR:  pc_sel = 2'd3;
          default: pc_sel = 2'd0;
        endcase
        case (cls)
          C_LUI:   wb_sel = 3'd1;
          C_AUIPC: wb_sel = 3'd2;
          C_ALU:   wb_sel = 3'd3;
          C_LW:    wb_sel = 3'd4;
          default: wb_sel = 3'd0;
        endcase
      end
      S_TRAP: begin
        trap = 1'b1;
        // A legal instruction can only get here by timing out in MEM.
        trap_cause = legal ? 2'd2 : 2'd1;
      end
      default: ;
    endcase
  end

endmodule
